branch_predictor: RTL and testbench

Dynamic branch predictor and resolution unit for the 5-stage MIPS pipeline. For a conditional branch in decode it produces the predicted-taken bit `brbitD`. It carries that prediction into execute, compares it with the resolved outcome to produce `branchCorrectE`, and trains a direct-mapped table of 2-bit saturating counters. Together, `brbitD` and `branchCorrectE` are the inputs that drive the PC-source branch mux select.

---
 rtl/bp_pkg.sv | 15 +
 rtl/bht_table.sv | 50 +++++
 rtl/branch_predictor.sv | 66 ++++++
 tb/tb_branch_predictor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor: 2-bit counter
// encodings, the counter reset value and the default table index width.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bhtCnt_t;

    localparam bhtCnt_t CNT_RESET     = WNT;
    localparam int      DEFAULT_IDX_W = 6;

endpackage

// File: rtl/bht_table.sv
// Direct-mapped table of 2-bit saturating counters with one combinational
// read port (forwarded from the write port) and one training write port.
module bht_table
    import bp_pkg::*;
#(
    parameter int IDX_W = DEFAULT_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rdIdx,
    output logic             rdMsb,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic             wrTaken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] ctrs [DEPTH];
    logic [1:0] wrCur;
    logic [1:0] wrVal;
    logic [1:0] rdCnt;

    always_comb begin
        wrCur = ctrs[wrIdx];
        wrVal = wrCur;
        if (wrTaken) begin
            if (wrCur != ST) wrVal = wrCur + 2'd1;
        end else begin
            if (wrCur != SNT) wrVal = wrCur - 2'd1;
        end
    end

    // A read of the entry being trained this cycle sees the trained value.
    always_comb begin
        rdCnt = ctrs[rdIdx];
        if (wrEn && (wrIdx == rdIdx)) rdCnt = wrVal;
    end

    assign rdMsb = rdCnt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ctrs[i] <= CNT_RESET;
        end else if (wrEn) begin
            ctrs[wrIdx] <= wrVal;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor and resolution unit: decode-stage lookup, D->E prediction
// register, execute-stage resolution, table training and mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = DEFAULT_IDX_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pcD,
    input  logic             branchD,
    input  logic             flushE,
    input  logic             takenE,
    output logic             brbitD,
    output logic             branchE,
    output logic             brbitE,
    output logic             branchCorrectE,
    output logic             mispredictE,
    output logic [CNT_W-1:0] mispredCount
);

    logic [IDX_W-1:0] idxD;
    logic [IDX_W-1:0] idxE;
    logic             unusedPcBits;

    assign idxD         = pcD[IDX_W+1:2];
    assign unusedPcBits = ^{pcD[31:IDX_W+2], pcD[1:0]};

    bht_table #(
        .IDX_W(IDX_W)
    ) uTable (
        .clk    (clk),
        .reset  (reset),
        .rdIdx  (idxD),
        .rdMsb  (brbitD),
        .wrEn   (branchE),
        .wrIdx  (idxE),
        .wrTaken(takenE)
    );

    // A flushed slot becomes a bubble, so it never trains the table.
    always_ff @(posedge clk) begin
        if (reset || flushE) begin
            branchE <= 1'b0;
            brbitE  <= 1'b0;
            idxE    <= '0;
        end else begin
            branchE <= branchD;
            brbitE  <= brbitD;
            idxE    <= idxD;
        end
    end

    assign branchCorrectE = ~branchE | (brbitE == takenE);
    assign mispredictE    = branchE & (brbitE != takenE);

    always_ff @(posedge clk) begin
        if (reset) begin
            mispredCount <= '0;
        end else if (mispredictE && (mispredCount != '1)) begin
            mispredCount <= mispredCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, randomized traffic
// against a behavioural model, and mispredict counter saturation.
module tb_branch_predictor;

    localparam int IDX_W = 6;
    localparam int CNT_W = 16;
    localparam int N     = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      pcD = '0;
    logic             branchD = 1'b0;
    logic             flushE = 1'b0;
    logic             takenE = 1'b0;
    logic             brbitD;
    logic             branchE;
    logic             brbitE;
    logic             branchCorrectE;
    logic             mispredictE;
    logic [CNT_W-1:0] mispredCount;

    int checks = 0;
    int errors = 0;

    // Behavioural model: counters as integers 0..3, one pending E-stage slot.
    int   ctr [N];
    logic mBranchE = 1'b0;
    logic mBrbitE = 1'b0;
    int   mIdxE = 0;
    int   mCount = 0;

    logic [4:0] expQ [$];

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        br;
        logic        fl;
        logic        tk;
        logic        chk;
        logic [4:0]  outs;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [$];

    branch_predictor #(
        .IDX_W(IDX_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pcD           (pcD),
        .branchD       (branchD),
        .flushE        (flushE),
        .takenE        (takenE),
        .brbitD        (brbitD),
        .branchE       (branchE),
        .brbitE        (brbitE),
        .branchCorrectE(branchCorrectE),
        .mispredictE   (mispredictE),
        .mispredCount  (mispredCount)
    );

    always #5 clk = ~clk;

    function automatic int idxOf(logic [31:0] pc);
        return int'(pc[IDX_W+1:2]);
    endfunction

    function automatic int trained(int c, logic up);
        if (up) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    function automatic logic modelPred();
        int i;
        int c;
        i = idxOf(pcD);
        c = ctr[i];
        if (mBranchE && (mIdxE == i)) c = trained(c, takenE);
        return (c >= 2);
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, input logic b, input logic f,
                         input logic t);
        @(negedge clk);
        reset   = r;
        pcD     = pc;
        branchD = b;
        flushE  = f;
        takenE  = t;
        #1;
    endtask

    // Advance the model across the rising edge using the inputs held this cycle.
    task automatic tick();
        logic p;
        logic mis;
        p = modelPred();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) ctr[i] = 1;
            mBranchE = 1'b0;
            mBrbitE  = 1'b0;
            mIdxE    = 0;
            mCount   = 0;
        end else begin
            if (mBranchE) begin
                mis = (mBrbitE != takenE);
                ctr[mIdxE] = trained(ctr[mIdxE], takenE);
                if (mis && mCount < (1 << CNT_W) - 1) mCount++;
            end
            if (flushE) begin
                mBranchE = 1'b0;
                mBrbitE  = 1'b0;
                mIdxE    = 0;
            end else begin
                mBranchE = branchD;
                mBrbitE  = p;
                mIdxE    = idxOf(pcD);
            end
        end
    endtask

    task automatic checkModel(input string tag);
        logic [4:0] e;
        expQ.push_back({modelPred(), mBranchE, mBrbitE,
                        ~mBranchE | (mBrbitE == takenE),
                        mBranchE & (mBrbitE != takenE)});
        e = expQ.pop_front();
        check1({tag, " outs"}, 32'({brbitD, branchE, brbitE, branchCorrectE, mispredictE}),
               32'(e));
        check1({tag, " cnt"}, 32'(mispredCount), 32'(mCount));
    endtask

    initial begin
        // Outputs packed as {brbitD, branchE, brbitE, branchCorrectE, mispredictE}.
        vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 16'd0});
        vecs.push_back('{1'b0, 32'h0040_0040, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00010, 16'd0});
        vecs.push_back('{1'b0, 32'h0040_0040, 1'b1, 1'b0, 1'b1, 1'b1, 5'b11001, 16'd0});
        vecs.push_back('{1'b0, 32'h0040_0040, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11110, 16'd1});
        vecs.push_back('{1'b0, 32'h0040_0040, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10110, 16'd1});
        vecs.push_back('{1'b0, 32'h0040_0040, 1'b1, 1'b1, 1'b0, 1'b1, 5'b10110, 16'd1});
        vecs.push_back('{1'b0, 32'h0040_0040, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10010, 16'd1});
        vecs.push_back('{1'b0, 32'h0000_0014, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00110, 16'd1});
        vecs.push_back('{1'b0, 32'h0000_0014, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11001, 16'd1});
        vecs.push_back('{1'b0, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10110, 16'd2});
        vecs.push_back('{1'b0, 32'h0000_001C, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00110, 16'd2});
        vecs.push_back('{1'b0, 32'h0000_001C, 1'b1, 1'b0, 1'b0, 1'b1, 5'b01010, 16'd2});
        vecs.push_back('{1'b0, 32'h0000_001C, 1'b1, 1'b0, 1'b0, 1'b1, 5'b01010, 16'd2});
        vecs.push_back('{1'b0, 32'h0000_001C, 1'b1, 1'b0, 1'b0, 1'b1, 5'b01010, 16'd2});
        vecs.push_back('{1'b0, 32'h0000_001C, 1'b1, 1'b0, 1'b0, 1'b1, 5'b01010, 16'd2});
        vecs.push_back('{1'b0, 32'h0000_001C, 1'b0, 1'b0, 1'b0, 1'b1, 5'b01010, 16'd2});
        vecs.push_back('{1'b0, 32'h0000_001C, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00010, 16'd2});
        vecs.push_back('{1'b0, 32'h0000_001C, 1'b0, 1'b0, 1'b1, 1'b1, 5'b01001, 16'd2});
        vecs.push_back('{1'b0, 32'h0000_001C, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00010, 16'd3});
        vecs.push_back('{1'b1, 32'h0040_0040, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11001, 16'd3});
        vecs.push_back('{1'b0, 32'h0040_0040, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00010, 16'd0});
        vecs.push_back('{1'b0, 32'h0000_001C, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00010, 16'd0});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].pc, vecs[i].br, vecs[i].fl, vecs[i].tk);
            if (vecs[i].chk) begin
                check1($sformatf("vec%0d outs", i),
                       32'({brbitD, branchE, brbitE, branchCorrectE, mispredictE}),
                       32'(vecs[i].outs));
                check1($sformatf("vec%0d cnt", i), 32'(mispredCount), 32'(vecs[i].cnt));
            end
            tick();
        end

        // Random traffic over a few indices so entries collide and forward often.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] pc;
            pc = $urandom;
            pc[IDX_W+1:2] = IDX_W'($urandom_range(0, 7));
            drive(($urandom_range(0, 99) == 0), pc, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
            checkModel($sformatf("rand%0d", n));
            tick();
        end

        // Force a mispredict on every cycle until the statistics counter saturates.
        drive(1'b1, 32'h0040_0040, 1'b0, 1'b0, 1'b0);
        tick();
        for (int n = 0; n < 70000 && mCount < 65535; n++) begin
            drive(1'b0, 32'h0040_0040, 1'b1, 1'b0, mBranchE ? ~mBrbitE : 1'b0);
            tick();
        end
        drive(1'b0, 32'h0040_0040, 1'b1, 1'b0, ~mBrbitE);
        check1("sat cnt full", 32'(mispredCount), 32'h0000_FFFF);
        check1("sat mispredictE", 32'(mispredictE), 32'd1);
        tick();
        drive(1'b0, 32'h0040_0040, 1'b0, 1'b0, 1'b0);
        check1("sat cnt held", 32'(mispredCount), 32'h0000_FFFF);
        checkModel("sat");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
